// File: rtl/gpio_cmd_bridge_pkg.sv
// rtl/gpio_cmd_bridge_pkg.sv - opcodes, FSM encoding and GPIO field layout for gpio_cmd_bridge
package gpio_cmd_bridge_pkg;

  localparam int GPIO_OPC_MSB = 31;
  localparam int GPIO_OPC_LSB = 24;
  localparam int GPIO_STB_BIT = 23;
  localparam int GPIO_ACK_BIT = 31;
  localparam int CNT_W        = 64;

  localparam logic [7:0] OPC_WRITE_CTRL = 8'h01;
  localparam logic [7:0] OPC_SOFT_RESET = 8'h02;
  localparam logic [7:0] OPC_SNAPSHOT   = 8'h03;
  localparam logic [7:0] OPC_READ_CTRL  = 8'h04;
  localparam logic [7:0] OPC_READ_BASE  = 8'h10;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    EXEC      = 2'd1,
    RST_PULSE = 2'd2,
    ACK       = 2'd3
  } state_t;

  // 24-bit window into a 64-bit shadow; chunk 3 lies past the counter width
  function automatic logic [23:0] read_chunk(input logic [CNT_W-1:0] shadow,
                                             input logic [1:0] chunk);
    case (chunk)
      2'd0:    read_chunk = shadow[23:0];
      2'd1:    read_chunk = shadow[47:24];
      2'd2:    read_chunk = {8'h00, shadow[63:48]};
      default: read_chunk = 24'h000000;
    endcase
  endfunction

endpackage

// File: rtl/gpio_cmd_bridge_strobe_sync_edge.sv
// rtl/gpio_cmd_bridge_strobe_sync_edge.sv - strobe rising-edge detect, 2-flop sync under GPIO_CDC_EN
module gpio_cmd_bridge_strobe_sync_edge (
  input  logic clk100,
  input  logic reset,
  input  logic strobe_i,
  output logic strobe_o,
  output logic rise_o
);

  logic prev_q;

`ifdef GPIO_CDC_EN
  logic sync1_q, sync2_q;

  always_ff @(posedge clk100 or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= strobe_i;
      sync2_q <= sync1_q;
    end
  end

  assign strobe_o = sync2_q;
`else
  assign strobe_o = strobe_i;
`endif

  // Resetting to 1 masks a strobe that is already high when reset releases
  always_ff @(posedge clk100 or posedge reset) begin
    if (reset) prev_q <= 1'b1;
    else       prev_q <= strobe_o;
  end

  assign rise_o = strobe_o & ~prev_q;

endmodule

// File: rtl/gpio_cmd_bridge.sv
// rtl/gpio_cmd_bridge.sv - GPIO command decoder for the BER datapath; GPIO_CDC_EN adds strobe sync
module gpio_cmd_bridge #(
  parameter int NB_GPIOS   = 32,
  parameter int NB_CNT     = 64,
  parameter int RST_CYCLES = 16
) (
  input  logic                clk100,
  input  logic                reset,
  input  logic [NB_GPIOS-1:0] i_gpo,
  input  logic [NB_CNT-1:0]   i_bit_count_i,
  input  logic [NB_CNT-1:0]   i_error_count_i,
  input  logic [NB_CNT-1:0]   i_bit_count_q,
  input  logic [NB_CNT-1:0]   i_error_count_q,
  output logic [NB_GPIOS-1:0] o_gpi,
  output logic                o_tx_enable,
  output logic                o_rx_enable,
  output logic [1:0]          o_offset,
  output logic                o_soft_reset,
  output logic                o_cmd_error
);
  import gpio_cmd_bridge_pkg::*;

  state_t                  state_q, state_d;
  logic [7:0]              opc_q, opc_d;
  logic [3:0]              pay_q, pay_d;
  logic [3:0]              ctrl_q, ctrl_d;
  logic [23:0]             data_q, data_d;
  logic [7:0]              cnt_q, cnt_d;
  logic                    ack_q, ack_d;
  logic                    soft_q, soft_d;
  logic                    err_q, err_d;
  logic [3:0][NB_CNT-1:0]  shd_q, shd_d;
  logic                    stb, stb_rise;
  logic                    unused_gpo;

  assign unused_gpo = ^i_gpo[GPIO_STB_BIT-1:4];

  gpio_cmd_bridge_strobe_sync_edge u_stb (
    .clk100   (clk100),
    .reset    (reset),
    .strobe_i (i_gpo[GPIO_STB_BIT]),
    .strobe_o (stb),
    .rise_o   (stb_rise)
  );

  always_ff @(posedge clk100 or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      opc_q   <= '0;
      pay_q   <= '0;
      ctrl_q  <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      soft_q  <= 1'b0;
      err_q   <= 1'b0;
      shd_q   <= '0;
    end else begin
      state_q <= state_d;
      opc_q   <= opc_d;
      pay_q   <= pay_d;
      ctrl_q  <= ctrl_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      soft_q  <= soft_d;
      err_q   <= err_d;
      shd_q   <= shd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    opc_d   = opc_q;
    pay_d   = pay_q;
    ctrl_d  = ctrl_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    shd_d   = shd_q;
    case (state_q)
      IDLE: begin
        if (stb_rise) begin
          opc_d   = i_gpo[GPIO_OPC_MSB:GPIO_OPC_LSB];
          pay_d   = i_gpo[3:0];
          state_d = EXEC;
        end
      end
      EXEC: begin
        state_d = ACK;
        if (opc_q == OPC_WRITE_CTRL) begin
          ctrl_d = pay_q;
          data_d = {20'h00000, pay_q};
        end else if (opc_q == OPC_SOFT_RESET) begin
          data_d  = '0;
          cnt_d   = 8'(RST_CYCLES);
          state_d = RST_PULSE;
        end else if (opc_q == OPC_SNAPSHOT) begin
          shd_d  = {i_error_count_q, i_bit_count_q, i_error_count_i, i_bit_count_i};
          data_d = {23'h000000, (i_error_count_i == '0) && (i_error_count_q == '0)};
        end else if (opc_q == OPC_READ_CTRL) begin
          data_d = {20'h00000, ctrl_q};
        end else if (opc_q[7:4] == OPC_READ_BASE[7:4]) begin
          data_d = read_chunk(shd_q[opc_q[3:2]], opc_q[1:0]);
        end else begin
          data_d = 24'hFFFFFF;
          err_d  = 1'b1;
        end
      end
      RST_PULSE: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q == 8'd1) state_d = ACK;
      end
      ACK: begin
        if (!stb) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered decodes of the next state keep ack and the pulse glitch-free
  assign ack_d  = (state_d == ACK);
  assign soft_d = (state_d == RST_PULSE);

  assign o_gpi        = {ack_q, opc_q[6:0], data_q};
  assign o_tx_enable  = ctrl_q[0];
  assign o_rx_enable  = ctrl_q[1];
  assign o_offset     = ctrl_q[3:2];
  assign o_soft_reset = soft_q;
  assign o_cmd_error  = err_q;

endmodule

// File: tb/tb_gpio_cmd_bridge.sv
// tb/tb_gpio_cmd_bridge.sv - directed self-checking bench for gpio_cmd_bridge
module tb_gpio_cmd_bridge;

`ifdef GPIO_CDC_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif

  logic        clk100 = 1'b0;
  logic        reset;
  logic [31:0] gpo;
  logic [63:0] bit_i, err_i, bit_q, err_q;
  logic [31:0] gpi;
  logic        tx_en, rx_en, soft_rst, cmd_err;
  logic [1:0]  offset;

  int n_chk  = 0;
  int n_fail = 0;
  int last_lat;
  logic [31:0] resp;

  always #5 clk100 = ~clk100;

  gpio_cmd_bridge dut (
    .clk100          (clk100),
    .reset           (reset),
    .i_gpo           (gpo),
    .i_bit_count_i   (bit_i),
    .i_error_count_i (err_i),
    .i_bit_count_q   (bit_q),
    .i_error_count_q (err_q),
    .o_gpi           (gpi),
    .o_tx_enable     (tx_en),
    .o_rx_enable     (rx_en),
    .o_offset        (offset),
    .o_soft_reset    (soft_rst),
    .o_cmd_error     (cmd_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_cmd(input logic [7:0] opc, input logic [22:0] pay, output logic [31:0] r);
    int n;
    gpo = {opc, 1'b1, pay};
    n = 0;
    do begin
      @(negedge clk100);
      n++;
    end while (!gpi[31] && n < 100);
    last_lat = n;
    chk("ack_rise", gpi[31], 1'b1);
    r = gpi;
    gpo[23] = 1'b0;
    @(negedge clk100);
    chk("ack_fall", gpi[31], 1'b0);
  endtask

  initial begin
    int cnt;
    bit saw_ack, soft_at_ack;

    reset = 1'b1;
    gpo   = 32'h01800003;
    bit_i = '0; err_i = '0; bit_q = '0; err_q = '0;
    repeat (3) @(negedge clk100);
    chk("rst_gpi", gpi, 32'h0);
    chk("rst_ctrl", {tx_en, rx_en, offset, soft_rst, cmd_err}, 6'b0);
    reset = 1'b0;

    // Strobe held across reset release must not execute
    repeat (10) @(negedge clk100);
    chk("held_gpi", gpi, 32'h0);
    chk("held_tx", tx_en, 1'b0);
    gpo[23] = 1'b0;
    repeat (2) @(negedge clk100);

    do_cmd(8'h01, 23'h5, resp);
    chk("wr_lat", last_lat, LAT);
    chk("wr_resp", resp, 32'h81000005);
    chk("wr_outs", {tx_en, rx_en, offset}, {1'b1, 1'b0, 2'd1});
    chk("wr_idle_gpi", gpi, 32'h01000005);

    do_cmd(8'h04, 23'h0, resp);
    chk("rdctrl", resp, 32'h84000005);

    bit_i = 64'h0000_1234_5678_9ABC;
    bit_q = 64'h0000_0000_0000_0077;
    do_cmd(8'h03, 23'h0, resp);
    chk("snap_ok", resp, 32'h83000001);
    bit_i = 64'hFFFF_FFFF_FFFF_FFFF;
    do_cmd(8'h12, 23'h0, resp);
    chk("rd_bi_c2", resp, 32'h92000000);
    do_cmd(8'h11, 23'h0, resp);
    chk("rd_bi_c1", resp, 32'h91123456);
    do_cmd(8'h10, 23'h0, resp);
    chk("rd_bi_c0", resp, 32'h90789ABC);
    do_cmd(8'h18, 23'h0, resp);
    chk("rd_bq_c0", resp, 32'h98000077);

    err_q = 64'hABCD_0000_0000_0001;
    do_cmd(8'h03, 23'h0, resp);
    chk("snap_err", resp, 32'h83000000);
    do_cmd(8'h1E, 23'h0, resp);
    chk("rd_eq_c2", resp, 32'h9E00ABCD);
    do_cmd(8'h1C, 23'h0, resp);
    chk("rd_eq_c0", resp, 32'h9C000001);
    do_cmd(8'h1F, 23'h0, resp);
    chk("rd_eq_c3", resp, 32'h9F000000);
    do_cmd(8'h10, 23'h0, resp);
    chk("rd_bi_resnap", resp, 32'h90FFFFFF);

    // Soft reset with a spurious second strobe edge mid-pulse
    gpo = 32'h02800000;
    cnt = 0;
    saw_ack = 1'b0;
    soft_at_ack = 1'b1;
    for (int i = 1; i <= 100 && !saw_ack; i++) begin
      if (i == 4) gpo[23] = 1'b0;
      if (i == 6) gpo[23] = 1'b1;
      @(negedge clk100);
      if (soft_rst) cnt++;
      if (gpi[31]) begin
        saw_ack = 1'b1;
        soft_at_ack = soft_rst;
      end
    end
    chk("sr_ack", saw_ack, 1'b1);
    chk("sr_len", cnt, 16);
    chk("sr_ack_after", soft_at_ack, 1'b0);
    chk("sr_resp", gpi, 32'h82000000);
    chk("sr_ctrl_kept", {tx_en, rx_en, offset}, {1'b1, 1'b0, 2'd1});
    gpo[23] = 1'b0;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk100);
      if (soft_rst || gpi[31]) cnt++;
    end
    chk("sr_single", cnt, 0);

    do_cmd(8'h7E, 23'h0, resp);
    chk("bad_resp", resp, 32'hFEFFFFFF);
    chk("bad_err", cmd_err, 1'b1);
    do_cmd(8'h04, 23'h0, resp);
    chk("bad_sticky", cmd_err, 1'b1);
    chk("rdctrl2", resp, 32'h84000005);

    // Reset in the middle of a pulse, strobe still high through release
    gpo = 32'h02800000;
    repeat (6) @(negedge clk100);
    chk("mid_pulse", soft_rst, 1'b1);
    reset = 1'b1;
    #1;
    chk("rst_kills_pulse", soft_rst, 1'b0);
    @(negedge clk100);
    chk("rst_clr", {cmd_err, tx_en, offset}, 4'b0);
    reset = 1'b0;
    repeat (25) @(negedge clk100);
    chk("post_rst_quiet", {soft_rst, gpi[31]}, 2'b0);
    gpo[23] = 1'b0;
    @(negedge clk100);

    do_cmd(8'h01, 23'hE, resp);
    chk("wr2_resp", resp, 32'h8100000E);
    chk("wr2_outs", {tx_en, rx_en, offset}, {1'b0, 1'b1, 2'd3});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
